// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a byte FIFO, read via a request/strobe port.
//   clk        : clock, all logic on posedge
//   reset      : synchronous, active-high
//   rxd        : asynchronous serial input, idles high
//   out_valid  : consumer requests a byte
//   out_data   : FIFO head byte, meaningful only while out_ready=1
//   out_ready  : byte delivered this cycle (out_valid && FIFO non-empty)
//   overrun    : sticky, a received byte was dropped because the FIFO was full
//   frame_err  : sticky, a stop bit was sampled low
module uart_rx_fifo #(
  parameter int unsigned CLK_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_ready,
  output logic       overrun,
  output logic       frame_err
);

  localparam int unsigned CW   = $clog2(CLK_PER_BIT) + 1;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned NW   = AW + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLK_PER_BIT - 1);
  localparam logic [NW-1:0] FULL_N  = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // 2-flop synchronizer, preset to the idle level
  logic rx_meta;
  logic rxs;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  // RX state machine
  rx_state_t      state;
  logic [CW-1:0]  cnt;
  logic [2:0]     idx;
  logic [7:0]     shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
            idx   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_M1) begin
            cnt        <= '0;
            shift[idx] <= rxs;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == BIT_M1) begin
            cnt <= '0;
            if (rxs) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_HIGH: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A completed frame with a good stop bit; the byte is written on this edge
  logic push_c;
  assign push_c = (state == STOP) && (cnt == BIT_M1) && rxs;

  // Byte FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [NW-1:0] count;
  logic          empty_c;
  logic          full_c;
  logic          pop_c;
  logic          do_push_c;

  assign empty_c   = (count == '0);
  assign full_c    = (count == FULL_N);
  assign out_ready = out_valid && !empty_c;
  assign pop_c     = out_ready;
  assign out_data  = mem[rd_ptr];
  // When full, a same-cycle pop frees the slot the push lands in
  assign do_push_c = push_c && (!full_c || pop_c);

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + NW'(do_push_c) - NW'(pop_c);
      if (push_c && !do_push_c) overrun <= 1'b1;
    end
  end

endmodule
